pipe_rca: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the 4-bit combinational rca.
- Splits a WIDTH-bit carry chain into STAGES registered chunks, adds subtract mode, carry-out and signed-overflow flags, and a valid/ready handshake with backpressure.
- Sits between operand-producing logic and a result consumer; also the drop-in target for the self-checking random adder benches.

---
 rtl/pipe_rca.sv | 115 +++++++++++
 tb/tb_pipe_rca.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit carry chain is cut into
// STAGES registered chunks, with a valid/ready handshake and global stall.
module pipe_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [STAGES-1:0] c_q, c_d, v_q, v_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic [STAGES-1:0] c_in, v_in;
  logic [CW:0]      chunk [STAGES];

  assign adv = !v_q[STAGES-1] || out_ready;

  // Stage k consumes what stage k-1 registered; stage 0 consumes the port,
  // with B already inverted and the carry forced to 1 for subtraction.
  always_comb begin
    a_in[0] = in_a;
    b_in[0] = in_sub ? ~in_b : in_b;
    c_in[0] = in_sub | in_cin;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = sum_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_in[k]};
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      c_d[k]   = c_q[k];
      v_d[k]   = v_q[k];
      if (adv) begin
        a_d[k]   = a_in[k];
        b_d[k]   = b_in[k];
        sum_d[k] = s_in[k];
        sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
        c_d[k]   = chunk[k][CW];
        v_d[k]   = v_in[k];
      end
    end
    // Carry into the MSB is recovered from the MSB's own sum bit and operands.
    if (adv) begin
      ovf_d = chunk[STAGES-1][CW]
            ^ (a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1] ^ chunk[STAGES-1][CW-1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign busy      = |v_q;

endmodule

// File: tb/tb_pipe_rca.sv
// Directed and randomised checks of pipe_rca at 16/4, plus an exhaustive
// sweep of a 4-bit single-stage instance.
module tb_pipe_rca;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, busy;
  logic [15:0] out_sum;

  logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub;
  logic [3:0]  s_in_a, s_in_b, s_out_sum;
  logic        s_out_valid, s_out_ready, s_out_cout, s_out_ovf, s_busy;

  int passed = 0;
  int total  = 0;

  logic [17:0] exp_q[$];
  logic [17:0] held, e18;
  logic        stall_prev;
  int          sent, cyc;
  logic [5:0]  e6;

  pipe_rca #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  pipe_rca #(.WIDTH(4), .STAGES(1)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] golden(logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    logic [15:0] bp;
    logic [16:0] full;
    logic        ovf;
    bp   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {16'b0, (sub | cin)};
    ovf  = (a[15] == bp[15]) && (full[15] != a[15]);
    return {full[16], ovf, full[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkLatency(input string tag, input logic [17:0] exp);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, {31'b0, (i == 3)});
      if (i < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checkOutput({tag, "_data"}, {14'b0, out_cout, out_ovf, out_sum}, {14'b0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitResult(input string tag, input logic [17:0] exp);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (out_valid) begin
        checkOutput(tag, {14'b0, out_cout, out_ovf, out_sum}, {14'b0, exp});
        got = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput({tag, "_arrived"}, {31'b0, got}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_in_sub = 1'b0;
    s_out_ready = 1'b1;
    #1;
    checkOutput("reset_outputs", {12'b0, out_valid, busy, out_cout, out_ovf, out_sum}, 32'd0);
    #12 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkLatency("wrap", {1'b1, 1'b0, 16'h0000});

    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    waitResult("ovf_pos", {1'b0, 1'b1, 16'h8000});
    waitResult("sub_neg", {1'b0, 1'b0, 16'hFFFE});

    $display("[TB] random stream with backpressure");
    sent = 0; cyc = 0; stall_prev = 1'b0;
    while ((sent < 128 || exp_q.size() > 0) && cyc < 3000) begin
      if (stall_prev) begin
        checkOutput("stall_hold", {13'b0, out_valid, out_cout, out_ovf, out_sum}, {13'b0, 1'b1, held});
      end
      out_ready = 1'($urandom % 2);
      in_valid  = (sent < 128);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      #1;
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin
        checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        held = {out_cout, out_ovf, out_sum};
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("rand_extra_result", 32'd1, 32'd0);
        end else begin
          e18 = exp_q.pop_front();
          checkOutput("rand_result", {14'b0, out_cout, out_ovf, out_sum}, {14'b0, e18});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(golden(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    checkOutput("rand_complete", {31'b0, (sent == 128 && exp_q.size() == 0)}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;

    $display("[TB] reset mid-stream");
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0002, 16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_drop", {30'b0, out_valid, busy}, 32'd0);
    #14 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("post_reset_quiet", {30'b0, out_valid, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b0);
    checkLatency("post_reset", {1'b0, 1'b0, 16'h0030});

    $display("[TB] 4-bit single-stage instance");
    s_in_a = 4'hF; s_in_b = 4'hF; s_in_cin = 1'b1; s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("small_directed", {25'b0, s_out_valid, s_out_cout, s_out_ovf, s_out_sum},
                {25'b0, 1'b1, 1'b1, 1'b0, 4'hF});
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] full;
      v = 9'(i);
      s_in_a = v[8:5]; s_in_b = v[4:1]; s_in_cin = v[0];
      full = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
      e6 = {full[4], (v[8] == v[4]) && (full[3] != v[8]), full[3:0]};
      @(posedge clk);
      @(negedge clk);
      checkOutput("small_sweep", {25'b0, s_out_valid, s_out_cout, s_out_ovf, s_out_sum},
                  {25'b0, 1'b1, e6});
    end
    s_in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
